// File: rtl/wb_serial_master.sv
// Byte-stream to Wishbone bridge: decodes 'W'/'R' command frames from an rx byte
// stream, runs one classic 32-bit Wishbone cycle, and returns the result on tx.
module wb_serial_master #(
  parameter int unsigned timeout_cycles = 1023
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  output logic        busy
);

  localparam int unsigned CntW = 16;
  localparam logic [CntW-1:0] CntLast = CntW'(timeout_cycles - 1);
  localparam logic [7:0] CmdWrite = 8'h57;
  localparam logic [7:0] CmdRead  = 8'h52;
  localparam logic [7:0] RespOk   = 8'h4B;
  localparam logic [7:0] RespErr  = 8'h45;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    DATA = 3'd2,
    BUS  = 3'd3,
    RESP = 3'd4
  } state_e;

  state_e           state_q;
  logic [1:0]       bcnt_q;
  logic [1:0]       idx_q;
  logic [CntW-1:0]  tmo_q;
  logic             we_q;
  logic             err_q;
  logic [31:0]      rdata_q;
  logic             rx_fire;
  logic             tx_fire;

  assign rx_fire = rx_valid && rx_ready;
  assign tx_fire = tx_valid && tx_ready;

  // Read response bytes go out MSB first, indexed 0..3.
  function automatic logic [7:0] rd_byte(input logic [31:0] d, input logic [1:0] i);
    case (i)
      2'd0: rd_byte = d[31:24];
      2'd1: rd_byte = d[23:16];
      2'd2: rd_byte = d[15:8];
      default: rd_byte = d[7:0];
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      bcnt_q   <= 2'd0;
      idx_q    <= 2'd0;
      tmo_q    <= '0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      rx_ready <= 1'b0;
      tx_valid <= 1'b0;
      tx_data  <= '0;
      wb_adr_o <= '0;
      wb_dat_o <= '0;
      wb_sel_o <= '0;
      wb_we_o  <= 1'b0;
      wb_cyc_o <= 1'b0;
      wb_stb_o <= 1'b0;
      busy     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          rx_ready <= 1'b1;
          bcnt_q   <= 2'd0;
          if (rx_fire && (rx_data == CmdWrite || rx_data == CmdRead)) begin
            we_q    <= (rx_data == CmdWrite);
            state_q <= ADDR;
            busy    <= 1'b1;
          end
        end
        ADDR: begin
          if (rx_fire) begin
            wb_adr_o <= {wb_adr_o[23:0], rx_data};
            bcnt_q   <= bcnt_q + 2'd1;
            if (bcnt_q == 2'd3) begin
              if (we_q) begin
                state_q <= DATA;
              end else begin
                state_q  <= BUS;
                rx_ready <= 1'b0;
                tmo_q    <= '0;
                wb_cyc_o <= 1'b1;
                wb_stb_o <= 1'b1;
                wb_sel_o <= 4'hF;
                wb_we_o  <= 1'b0;
              end
            end
          end
        end
        DATA: begin
          if (rx_fire) begin
            wb_dat_o <= {wb_dat_o[23:0], rx_data};
            bcnt_q   <= bcnt_q + 2'd1;
            if (bcnt_q == 2'd3) begin
              state_q  <= BUS;
              rx_ready <= 1'b0;
              tmo_q    <= '0;
              wb_cyc_o <= 1'b1;
              wb_stb_o <= 1'b1;
              wb_sel_o <= 4'hF;
              wb_we_o  <= 1'b1;
            end
          end
        end
        BUS: begin
          // err beats ack, and either beats an expiring timeout
          if (wb_err_i || wb_ack_i || tmo_q == CntLast) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_sel_o <= 4'h0;
            wb_we_o  <= 1'b0;
            tx_valid <= 1'b1;
            idx_q    <= 2'd0;
            state_q  <= RESP;
            if (wb_err_i || !wb_ack_i) begin
              err_q   <= 1'b1;
              tx_data <= RespErr;
            end else begin
              err_q <= 1'b0;
              if (we_q) begin
                tx_data <= RespOk;
              end else begin
                rdata_q <= wb_dat_i;
                tx_data <= wb_dat_i[31:24];
              end
            end
          end else begin
            tmo_q <= tmo_q + 16'd1;
          end
        end
        RESP: begin
          if (tx_fire) begin
            if (err_q || we_q || idx_q == 2'd3) begin
              tx_valid <= 1'b0;
              rx_ready <= 1'b1;
              busy     <= 1'b0;
              state_q  <= IDLE;
            end else begin
              idx_q   <= idx_q + 2'd1;
              tx_data <= rd_byte(rdata_q, idx_q + 2'd1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/wb_serial_master.md
Name: wb_serial_master

Overview:
- Byte-stream-to-Wishbone bridge. Acts as a Wishbone initiator (master) driven by a command byte stream, for example from a UART receiver.
- Decodes read/write frames, runs single 32-bit classic Wishbone cycles on a free master port of the interconnect, and returns response bytes on a transmit byte stream.
- Provides host-side debug and loading access to BRAM, DDR and peripherals without the CPU.

Parameters:
- timeout_cycles, 1023: max cycles a bus cycle waits for ack/err before abort; legal range 1..65535.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- rx_data  in  8  received byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  bridge accepts rx byte this cycle
- tx_data  out  8  response byte
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  sink accepts tx byte this cycle
- wb_adr_o  out  32  Wishbone address
- wb_dat_o  out  32  write data
- wb_dat_i  in  32  read data
- wb_sel_o  out  4  byte selects, always 4'hF during a cycle
- wb_we_o  out  1  write enable
- wb_cyc_o  out  1  cycle
- wb_stb_o  out  1  strobe
- wb_ack_i  in  1  acknowledge
- wb_err_i  in  1  error
- busy  out  1  high in every state except IDLE

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-low (reset_n), sampled on the rising edge.
- Reset values: rx_ready=0, tx_valid=0, tx_data=0, wb_cyc_o=0, wb_stb_o=0, wb_we_o=0, wb_sel_o=0, wb_adr_o=0, wb_dat_o=0, busy=0, state=IDLE.
- Reset asserted mid-cycle drops cyc/stb on that edge and discards any partial frame.
- Byte transfers: an rx byte is consumed on an edge where rx_valid&&rx_ready. A tx byte completes on an edge where tx_valid&&tx_ready. tx_data stays stable while tx_valid=1 and not yet accepted.
- Frames: all fields are MSB byte first.
  - Write: 0x57 ('W'), A3 A2 A1 A0, D3 D2 D1 D0. Response: 0x4B ('K').
  - Read: 0x52 ('R'), A3 A2 A1 A0. Response: D3 D2 D1 D0.
  - Failure of either frame type: single byte 0x45 ('E').
- State machine: IDLE, ADDR, DATA, BUS, RESP.
  - IDLE: rx_ready=1. 0x57 sets we and goes to ADDR. 0x52 clears we and goes to ADDR. Any other byte is dropped silently and the state stays IDLE.
  - ADDR: rx_ready=1. Shifts 4 bytes into wb_adr_o (adr <= {adr[23:0],byte}). After the 4th byte: DATA if we, else BUS.
  - DATA: rx_ready=1. Shifts 4 bytes into wb_dat_o the same way, then goes to BUS.
  - BUS: rx_ready=0.
    - The first BUS cycle drives cyc=stb=1, sel=4'hF, and we as latched. Address and data are held constant for the whole cycle.
    - Timeout counter is 16 bits, cleared on BUS entry and incremented each BUS cycle without ack/err.
    - On an edge sampling ack=1 (and err=0): cyc/stb go to 0 on that same edge. A read latches wb_dat_i into a 32-bit response register. Go to RESP.
    - err=1: cyc/stb to 0, result is 'E'. err has priority over a simultaneous ack.
    - Counter reaches timeout_cycles with no ack/err: cyc/stb to 0, result is 'E'. An ack or err arriving in the same cycle the timeout expires takes priority over the timeout.
    - wb_we_o returns to 0 when cyc drops.
  - RESP: rx_ready=0, tx_valid=1.
    - Write OK: sends 0x4B once.
    - Read OK: sends 4 bytes MSB first, using a 2-bit byte index that advances on each accepted byte.
    - Error: sends 0x45 once.
    - After the last byte is accepted: tx_valid=0 on the next cycle and state returns to IDLE.
- Latency: ack sampled at edge N gives tx_valid=1 after edge N+1 at the latest. Minimum turnaround from last rx byte accepted to cyc=1 is 1 edge.
- Bytes arriving while rx_ready=0 are not consumed. The upstream source holds them until accepted.
- No inter-byte timeout. A partial frame waits indefinitely; it is cleared only by reset.
- The bridge never asserts cyc across two transactions, and never asserts stb without cyc.

Test Plan:
1. Write 57 40 00 00 10 DE AD BE EF, slave acks after 3 cycles -> one cycle with adr=0x40000010, dat_o=0xDEADBEEF, we=1, sel=F; cyc high exactly until the ack edge; tx byte 0x4B; busy returns to 0.
2. Read 52 00 00 00 04, slave returns 0x12345678 with ack -> we=0; tx bytes 12 34 56 78 in order; tx_ready toggled randomly, no byte lost or duplicated.
3. Read to an address whose slave never acks, timeout_cycles=16 -> cyc deasserted after exactly 16 BUS cycles; tx byte 0x45; next frame is processed normally.
4. Slave asserts ack and err in the same cycle -> response 0x45; cyc drops on that edge.
5. Garbage bytes 00 FF 41 followed by a valid read frame -> garbage ignored, no bus cycle for it; read completes normally.
6. Assert reset_n=0 while in BUS with cyc=1, and again mid-ADDR -> all outputs at reset values after the edge; a subsequent full frame succeeds.
